mult_seq_par: RTL and testbench



---
 rtl/mult_seq_par.sv | 123 ++++++++++++
 tb/tb_mult_seq_par.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_par.sv
// mult_seq_par: multi-cycle signed shift-add multiplier with operand/result parity and a req/ack handshake.
// Define MULT_ERR_CNT_EN to add the saturating parity-error counter output err_cnt.
module mult_seq_par #(
  parameter int WIDTH      = 16,
  parameter bit PARITY_ODD = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   arg_a,
  input  logic                      arg_a_parity,
  input  logic signed [WIDTH-1:0]   arg_b,
  input  logic                      arg_b_parity,
  input  logic                      req,
  output logic                      ack,
  output logic signed [2*WIDTH-1:0] result,
  output logic                      result_parity,
  output logic                      result_rdy,
  output logic                      arg_parity_error
`ifdef MULT_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]      err_cnt
`endif
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [PW-1:0]     acc;
  logic              neg;
  logic              perr;

  logic              accept;
  logic              parity_bad;
  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic [PW-1:0]     final_val;

  // Unsigned magnitudes: the most negative operand maps to 2^(WIDTH-1) without overflow.
  assign abs_a      = arg_a[WIDTH-1] ? (~arg_a + WIDTH'(1)) : arg_a;
  assign abs_b      = arg_b[WIDTH-1] ? (~arg_b + WIDTH'(1)) : arg_b;
  assign parity_bad = (arg_a_parity != ((^arg_a) ^ PARITY_ODD)) ||
                      (arg_b_parity != ((^arg_b) ^ PARITY_ODD));
  assign accept     = (state == IDLE) && req;
  assign final_val  = perr ? '0 : (neg ? (~acc + PW'(1)) : acc);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (req) state_next = parity_bad ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack              <= 1'b0;
      result_rdy       <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
      cnt              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      acc              <= '0;
      neg              <= 1'b0;
      perr             <= 1'b0;
    end else begin
      ack        <= accept;
      result_rdy <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (req) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= arg_a[WIDTH-1] ^ arg_b[WIDTH-1];
            perr   <= parity_bad;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        DONE: begin
          result           <= final_val;
          result_parity    <= (^final_val) ^ PARITY_ODD;
          arg_parity_error <= perr;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (accept && parity_bad && (err_cnt != {ERR_CNT_W{1'b1}}))
      err_cnt <= err_cnt + ERR_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_mult_seq_par.sv
// Directed self-checking bench for mult_seq_par: a WIDTH=16 even-parity instance and a
// WIDTH=8 odd-parity instance (ERR_CNT_W=2) sharing clock and reset.
module tb_mult_seq_par;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a16, b16;
  logic        pa16, pb16, req16;
  logic        ack16, rp16, rdy16, pe16;
  logic [31:0] result16;

  logic [7:0]  a8, b8;
  logic        pa8, pb8, req8;
  logic        ack8, rp8, rdy8, pe8;
  logic [15:0] result8;

`ifdef MULT_ERR_CNT_EN
  logic [7:0]  err16;
  logic [1:0]  err8;
`endif

  mult_seq_par #(.WIDTH(16), .PARITY_ODD(1'b0), .ERR_CNT_W(8)) u_dut16 (
    .clk(clk), .rst(rst),
    .arg_a(a16), .arg_a_parity(pa16), .arg_b(b16), .arg_b_parity(pb16),
    .req(req16), .ack(ack16), .result(result16), .result_parity(rp16),
    .result_rdy(rdy16), .arg_parity_error(pe16)
`ifdef MULT_ERR_CNT_EN
    , .err_cnt(err16)
`endif
  );

  mult_seq_par #(.WIDTH(8), .PARITY_ODD(1'b1), .ERR_CNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst),
    .arg_a(a8), .arg_a_parity(pa8), .arg_b(b8), .arg_b_parity(pb8),
    .req(req8), .ack(ack8), .result(result8), .result_parity(rp8),
    .result_rdy(rdy8), .arg_parity_error(pe8)
`ifdef MULT_ERR_CNT_EN
    , .err_cnt(err8)
`endif
  );

  // Selects which instance the generic operation task drives and observes.
  logic        sel8 = 1'b0;
  logic        cur_ack, cur_rdy, cur_rp, cur_pe;
  logic [31:0] cur_result;
  assign cur_ack    = sel8 ? ack8 : ack16;
  assign cur_rdy    = sel8 ? rdy8 : rdy16;
  assign cur_rp     = sel8 ? rp8  : rp16;
  assign cur_pe     = sel8 ? pe8  : pe16;
  assign cur_result = sel8 ? {16'h0000, result8} : result16;

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Issues one command, checks the single-cycle ack, and returns the result_rdy latency
  // in edges after the acceptance edge (-1 if it never came within the budget).
  task automatic run_op(input bit w8, input logic [15:0] a, input logic pa,
                        input logic [15:0] b, input logic pb, output int lat);
    sel8 = w8;
    if (w8) begin a8 = a[7:0]; pa8 = pa; b8 = b[7:0]; pb8 = pb; req8 = 1'b1; end
    else    begin a16 = a;     pa16 = pa; b16 = b;    pb16 = pb; req16 = 1'b1; end
    tick();
    check("ack_pulse", 64'(cur_ack), 64'(1));
    req8  = 1'b0;
    req16 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) check("ack_single", 64'(cur_ack), 64'(0));
      if (cur_rdy) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input int lat_exp,
                               input logic [31:0] r, input logic rp, input logic pe);
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_result"},  64'(cur_result), 64'(r));
    check({tag, "_rparity"}, 64'(cur_rp), 64'(rp));
    check({tag, "_perr"},    64'(cur_pe), 64'(pe));
  endtask

  initial begin
    int lat;
    bit saw_rdy;
    int n_acks;
    int ack_at[8];

    rst = 1'b1;
    req16 = 1'b0; a16 = '0; b16 = '0; pa16 = 1'b0; pb16 = 1'b0;
    req8  = 1'b0; a8  = '0; b8  = '0; pa8  = 1'b0; pb8  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_ack16",    64'(ack16),    64'(0));
    check("rst_rdy16",    64'(rdy16),    64'(0));
    check("rst_result16", 64'(result16), 64'(0));
    check("rst_rp16",     64'(rp16),     64'(0));
    check("rst_pe16",     64'(pe16),     64'(0));
    check("rst_rdy8",     64'(rdy8),     64'(0));
    check("rst_result8",  64'(result8),  64'(0));
`ifdef MULT_ERR_CNT_EN
    check("rst_err16",    64'(err16),    64'(0));
    check("rst_err8",     64'(err8),     64'(0));
`endif

    // 3 * -5 = -15
    run_op(1'b0, 16'd3, 1'b0, 16'hFFFB, 1'b1, lat);
    expect_result("m3xm5", lat, 17, 32'hFFFF_FFF1, 1'b1, 1'b0);
    tick();
    check("rdy_one_cycle", 64'(rdy16),    64'(0));
    check("result_held",   64'(result16), 64'(32'hFFFF_FFF1));

    // zero operand still takes the full latency
    run_op(1'b0, 16'd0, 1'b0, 16'd5, 1'b0, lat);
    expect_result("zero", lat, 17, 32'h0000_0000, 1'b0, 1'b0);

    // bad parity on arg_a
    run_op(1'b0, 16'd5, 1'b1, 16'd7, 1'b1, lat);
    expect_result("perr16", lat, 1, 32'h0000_0000, 1'b0, 1'b1);
`ifdef MULT_ERR_CNT_EN
    check("err16_inc", 64'(err16), 64'(1));
`endif

    // most negative squared
    run_op(1'b0, 16'h8000, 1'b1, 16'h8000, 1'b1, lat);
    expect_result("minxmin16", lat, 17, 32'h4000_0000, 1'b1, 1'b0);

    // reset in the middle of 100 * 200
    sel8 = 1'b0;
    saw_rdy = 1'b0;
    a16 = 16'd100; pa16 = 1'b1; b16 = 16'd200; pb16 = 1'b1; req16 = 1'b1;
    tick();
    req16 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      saw_rdy |= rdy16;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ack",    64'(ack16),    64'(0));
    check("abort_rdy",    64'(rdy16),    64'(0));
    check("abort_result", 64'(result16), 64'(0));
    check("abort_rp",     64'(rp16),     64'(0));
    check("abort_pe",     64'(pe16),     64'(0));
`ifdef MULT_ERR_CNT_EN
    check("abort_err16",  64'(err16),    64'(0));
`endif
    for (int i = 0; i < 25; i++) begin
      tick();
      saw_rdy |= rdy16;
    end
    check("abort_no_rdy", 64'(saw_rdy), 64'(0));
    run_op(1'b0, 16'd100, 1'b1, 16'd200, 1'b1, lat);
    expect_result("after_abort", lat, 17, 32'd20000, 1'b1, 1'b0);

    // req held high: back-to-back commands, -1 * 1
    sel8 = 1'b0;
    n_acks = 0;
    a16 = 16'hFFFF; pa16 = 1'b0; b16 = 16'd1; pb16 = 1'b1; req16 = 1'b1;
    for (int i = 0; i < 56; i++) begin
      tick();
      if (ack16) begin
        if (n_acks < 8) ack_at[n_acks] = i;
        n_acks++;
      end
      if (rdy16) begin
        check("held_result", 64'(result16), 64'(32'hFFFF_FFFF));
        check("held_rp",     64'(rp16),     64'(0));
      end
    end
    req16 = 1'b0;
    check("held_ack_count", 64'(n_acks), 64'(4));
    check("held_ack_first", 64'(ack_at[0]), 64'(0));
    check("held_ack_gap1",  64'(ack_at[1] - ack_at[0]), 64'(18));
    check("held_ack_gap2",  64'(ack_at[2] - ack_at[1]), 64'(18));
    for (int i = 0; i < 20; i++) tick();

    // WIDTH=8 odd-parity instance
    run_op(1'b1, 16'h007F, 1'b0, 16'h0002, 1'b0, lat);
    expect_result("odd8_7fx2", lat, 9, 32'h0000_00FE, 1'b0, 1'b0);
    run_op(1'b1, 16'h0080, 1'b0, 16'h0080, 1'b0, lat);
    expect_result("odd8_minxmin", lat, 9, 32'h0000_4000, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      run_op(1'b1, 16'h007F, 1'b1, 16'h0002, 1'b0, lat);
      expect_result("odd8_perr", lat, 1, 32'h0000_0000, 1'b1, 1'b1);
`ifdef MULT_ERR_CNT_EN
      check("err8_sat", 64'(err8), 64'((k > 3) ? 3 : k));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
